bitbang_spi_master: RTL and testbench
=====================================

# bitbang_spi_master

Bit-banged SPI master that pulls W-bit words from a show-ahead byte source, shifts them out MSB-first in SPI mode 0, and returns each word captured from MISO through a one-cycle strobe. It sits between an on-chip data source, such as the companion `hello_rom` greeting generator, and external SPI pins. SCK runs at clock/2. CS_n stays low across back-to-back words.

## Interface
Parameters:
- W, default 8: word width in bits, W ≥ 2.

Ports:
- Reset and clock: one clock; reset is asynchronous and active-low.
- reset, input, 1: asynchronous, active-low reset.
- clock, input, 1: system clock; all state changes on the rising edge.
- in, input, W: source word; valid whenever empty=0.
- get, output, 1: combinational pop strobe; the source advances on the same clock edge.
- empty, input, 1: source has no word.
- out, output, W: last received word; held until the next put.
- put, output, 1: registered, one-cycle strobe; out is valid in the same cycle.
- spi_cs_n, output, 1: chip select, active-low.
- spi_clock, output, 1: SCK, idle level 0.
- spi_mosi, output, 1: data out, always equal to the shift-register MSB.
- spi_miso, input, 1: data in.

## Operation
- States:
  - IDLE: cs_n=1, sck=0.
  - LOW: sck=0; MOSI is being set up.
  - HIGH: sck=1; MISO is being held.
- IDLE, empty=0:
  - get=1; on the edge, shift register ← in, bit counter ← 0, cs_n ← 0, go to LOW.
- LOW → HIGH, one cycle:
  - sck ← 1.
  - Capture register ← {capture[W-2:0], spi_miso} (sampled on the SCK rising edge).
- HIGH → LOW for bits 0..W-2:
  - sck ← 0, shift register ← shift register << 1, counter ← counter + 1.
- HIGH on the last bit (counter = W-1):
  - put ← 1 next cycle; out ← the fully captured word, including the bit sampled on the last rising edge.
  - empty=0: get=1 in this cycle, load the next word, stay selected, go to LOW.
  - empty=1: cs_n ← 1, sck ← 0, go to IDLE.
- get is never asserted while empty=1.
- MOSI is 0 in IDLE and after reset.
- A popped word is always transmitted completely unless reset intervenes.

Companion `hello_rom` (clock, reset, get, out[7:0], empty):
- Holds the 14-byte ASCII string "Hello, World!\n".
- A 4-bit index resets to 0; out = rom[index], combinational.
- empty=1 once the index reaches 14.
- get with empty=0 increments the index.
- The source plays its content once and never wraps.

## Timing
- Reset values: cs_n=1, spi_clock=0, spi_mosi=0, put=0, out=0, get=0, state IDLE.
- Start latency: cs_n falls on the edge after the first IDLE cycle with empty=0.
- Per word: exactly 2W clocks. SCK period is 2 clocks at 50 % duty.
- Back-to-back words have no gap; cs_n stays low continuously.
- put fires 2W cycles after the corresponding get.
- After the last word, cs_n rises on the edge that ends the last HIGH phase.
- Any new frame needs at least one IDLE cycle, so minimum cs_n high is 1 clock.
- empty rising mid-word has no effect until the word boundary.
- Reset asserted mid-word:
  - Outputs return to reset values immediately.
  - The partial word is discarded; no put is issued.
  - The word already popped is lost.

## Structure
- Shared package constants:
  - the state encoding (IDLE/LOW/HIGH);
  - default W=8;
  - the hello string length 14.
- Natural sub-module: `spi_shift_reg`, a W-bit TX shift register plus RX capture register with load/shift/sample enables.
- `hello_rom` is a separate top-level source, not part of this block.

## Test plan
- Loopback (MISO tied to MOSI) with `hello_rom`:
  - 14 put strobes with out = 0x48,'e','l','l','o',…,0x0A.
  - Puts spaced exactly 16 clocks apart.
  - cs_n low continuously for 14×16 clocks, then high; afterwards empty=1 and get never fires.
- Single word 0xA5, source empty afterwards:
  - MOSI samples at the SCK rising edges read 1,0,1,0,0,1,0,1.
  - cs_n goes high after 16 clocks.
- MISO tied to 1 while sending 0x00: put with out=0xFF.
- Reset at cycle 7 of a word:
  - cs_n=1, sck=0 and mosi=0 immediately; no put.
  - After release, the next word starts cleanly.
- Source empty from reset: cs_n, sck and get remain idle for 100 clocks.
- Empty toggling between words:
  - Gaps produce a cs_n high pulse of at least 1 clock.
  - Word contents are unaffected.

Source files
------------

// File: rtl/bitbang_spi_master_pkg.sv
// Shared constants and state encoding for the bit-banged SPI master.
// Also carries the length of the companion greeting source.
package bitbang_spi_master_pkg;

  localparam int W_DEF     = 8;
  localparam int HELLO_LEN = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/bitbang_spi_master_if.sv
// Source handshake, received-word strobe and SPI pins of the master.
// master = the SPI block, slave = its environment.
interface bitbang_spi_master_if
  import bitbang_spi_master_pkg::*;
#(
  parameter int W = W_DEF
);

  logic [W-1:0] in;
  logic         get;
  logic         empty;
  logic [W-1:0] out;
  logic         put;
  logic         spi_cs_n;
  logic         spi_clock;
  logic         spi_mosi;
  logic         spi_miso;

  modport master (
    input  in, empty, spi_miso,
    output get, out, put,
    output spi_cs_n, spi_clock, spi_mosi
  );

  modport slave (
    output in, empty, spi_miso,
    input  get, out, put,
    input  spi_cs_n, spi_clock, spi_mosi
  );

endinterface

// File: rtl/bitbang_spi_master_shift_reg.sv
// TX shift register (MSB first) and RX capture register.
// Load takes priority over shift on the TX side.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         sample,
  input  logic [W-1:0] d,
  input  logic         miso,
  output logic         msb,
  output logic [W-1:0] cap
);

  logic [W-1:0] tx;
  logic [W-1:0] rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= '0;
      rx <= '0;
    end else begin
      if (load)
        tx <= d;
      else if (shift)
        tx <= {tx[W-2:0], 1'b0};
      if (sample)
        rx <= {rx[W-2:0], miso};
    end
  end

  assign msb = tx[W-1];
  assign cap = rx;

endmodule

// File: rtl/bitbang_spi_master.sv
// Bit-banged SPI mode-0 master: pops words, shifts MSB first,
// returns each captured MISO word on a one-cycle put strobe.
module bitbang_spi_master
  import bitbang_spi_master_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  bitbang_spi_master_if.master  bus
);

  localparam int CW = $clog2(W);

  state_t         state;
  state_t         nstate;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           pop;
  logic           load;
  logic           shift;
  logic           sample;
  logic [W-1:0]   ld_data;
  logic [W-1:0]   cap;
  logic           msb;
  logic           cs_n_q;
  logic           sck_q;
  logic           put_q;
  logic [W-1:0]   out_q;

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    nstate = state;
    pop    = 1'b0;
    load   = 1'b0;
    shift  = 1'b0;
    sample = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          nstate = LOW;
        end
      end
      LOW: begin
        sample = 1'b1;
        nstate = HIGH;
      end
      HIGH: begin
        if (!last) begin
          shift  = 1'b1;
          nstate = LOW;
        end else if (!bus.empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          nstate = LOW;
        end else begin
          // reload with zero so MOSI idles low
          load   = 1'b1;
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  assign ld_data = pop ? bus.in : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cs_n_q <= 1'b1;
      sck_q  <= 1'b0;
      put_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= nstate;
      cs_n_q <= (nstate == IDLE);
      sck_q  <= (nstate == HIGH);
      put_q  <= (state == HIGH) && last;
      if (load)
        cnt <= '0;
      else if (shift)
        cnt <= cnt + 1'b1;
      if ((state == HIGH) && last)
        out_q <= cap;
    end
  end

  spi_shift_reg #(
    .W (W)
  ) u_sr (
    .clk    (clock),
    .rst_n  (reset),
    .load   (load),
    .shift  (shift),
    .sample (sample),
    .d      (ld_data),
    .miso   (bus.spi_miso),
    .msb    (msb),
    .cap    (cap)
  );

  // no pop may reach the source while reset is held
  assign bus.get       = pop & reset;
  assign bus.out       = out_q;
  assign bus.put       = put_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_clock = sck_q;
  assign bus.spi_mosi  = msb;

endmodule

// File: tb/tb_bitbang_spi_master.sv
// Directed bench: show-ahead byte source model, negedge monitor,
// hand-computed expectations for loopback, MOSI order, reset, gaps.
module tb_bitbang_spi_master;
  import bitbang_spi_master_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bitbang_spi_master_if #(.W(8)) bus ();

  bitbang_spi_master #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] mem [0:15];
  int         len = 0;
  int         ridx;
  logic       hold = 1'b0;
  logic       loop = 1'b0;
  logic       miso_val = 1'b0;
  logic       src_clr = 1'b1;
  logic       mon_clr = 1'b1;

  assign bus.in       = (ridx < 16) ? mem[ridx] : 8'h00;
  assign bus.empty    = (ridx >= len) || hold;
  assign bus.spi_miso = loop ? bus.spi_mosi : miso_val;

  always @(posedge clock) begin
    if (src_clr)
      ridx <= 0;
    else if (bus.get)
      ridx <= ridx + 1;
  end

  int         cyc, cs_fall, cs_low, sck_hi, gets, get_empty;
  int         hirun;
  logic       framed, cs_prev;
  logic [7:0] mosi_bits;
  logic [7:0] put_out [$];
  int         put_cyc [$];
  int         gaps [$];

  always @(negedge clock) begin
    if (mon_clr) begin
      cyc       <= 0;
      cs_fall   <= 0;
      cs_low    <= 0;
      sck_hi    <= 0;
      gets      <= 0;
      get_empty <= 0;
      hirun     <= 0;
      framed    <= 1'b0;
      mosi_bits <= 8'h00;
      put_out.delete();
      put_cyc.delete();
      gaps.delete();
    end else begin
      cyc <= cyc + 1;
      if (bus.put) begin
        put_out.push_back(bus.out);
        put_cyc.push_back(cyc);
      end
      if (!bus.spi_cs_n) begin
        cs_low <= cs_low + 1;
        framed <= 1'b1;
      end
      if (cs_prev && !bus.spi_cs_n) begin
        cs_fall <= cs_fall + 1;
        if (framed) gaps.push_back(hirun);
      end
      hirun <= bus.spi_cs_n ? hirun + 1 : 0;
      if (bus.spi_clock) begin
        sck_hi    <= sck_hi + 1;
        mosi_bits <= {mosi_bits[6:0], bus.spi_mosi};
      end
      if (bus.get) gets <= gets + 1;
      if (bus.get && bus.empty) get_empty <= get_empty + 1;
    end
    cs_prev <= bus.spi_cs_n;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_test();
    @(negedge clock);
    mon_clr = 1'b1;
    src_clr = 1'b1;
    len     = 0;
    hold    = 1'b0;
    @(negedge clock);
  endtask

  task automatic go(input int n);
    len     = n;
    src_clr = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_puts(input int n, input int budget, input string tag);
    int k = 0;
    while (put_out.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (put_out.size() < n) chk(tag, put_out.size(), n);
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string tag);
    int k = 0;
    @(negedge clock);
    while (bus.spi_cs_n !== lvl && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (bus.spi_cs_n !== lvl) chk(tag, bus.spi_cs_n, lvl);
  endtask

  string hello = "Hello, World!\n";
  int    bad_gap;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_cs_n", bus.spi_cs_n, 1);
    chk("rst_sck", bus.spi_clock, 0);
    chk("rst_mosi", bus.spi_mosi, 0);
    chk("rst_put", bus.put, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_get", bus.get, 0);
    reset = 1'b1;

    // empty source: nothing moves for 100 clocks
    start_test();
    go(0);
    repeat (100) @(negedge clock);
    chk("idle_cs_fall", cs_fall, 0);
    chk("idle_sck", sck_hi, 0);
    chk("idle_get", gets, 0);
    chk("idle_cs_n", bus.spi_cs_n, 1);

    // loopback greeting
    start_test();
    for (int i = 0; i < HELLO_LEN; i++) mem[i] = hello[i];
    loop = 1'b1;
    go(HELLO_LEN);
    wait_puts(HELLO_LEN, 300, "hello_timeout");
    repeat (8) @(negedge clock);
    chk("hello_nput", put_out.size(), HELLO_LEN);
    for (int i = 0; i < HELLO_LEN && i < put_out.size(); i++)
      chk($sformatf("hello_b%0d", i), put_out[i], hello[i]);
    bad_gap = 0;
    for (int i = 1; i < put_cyc.size(); i++)
      if (put_cyc[i] - put_cyc[i-1] != 16) bad_gap++;
    chk("hello_spacing", bad_gap, 0);
    chk("hello_cs_low", cs_low, HELLO_LEN * 16);
    chk("hello_cs_fall", cs_fall, 1);
    chk("hello_gets", gets, HELLO_LEN);
    chk("hello_get_empty", get_empty, 0);
    chk("hello_cs_end", bus.spi_cs_n, 1);

    // single 0xA5, MISO low
    start_test();
    loop = 1'b0;
    miso_val = 1'b0;
    mem[0] = 8'hA5;
    go(1);
    wait_puts(1, 60, "a5_timeout");
    repeat (4) @(negedge clock);
    chk("a5_mosi_bits", mosi_bits, 8'hA5);
    chk("a5_sck_hi", sck_hi, 8);
    chk("a5_cs_low", cs_low, 16);
    chk("a5_out", put_out.size() > 0 ? put_out[0] : 8'hxx, 8'h00);
    chk("a5_mosi_idle", bus.spi_mosi, 0);
    chk("a5_cs_end", bus.spi_cs_n, 1);

    // 0x00 out, MISO high
    start_test();
    miso_val = 1'b1;
    mem[0] = 8'h00;
    go(1);
    wait_puts(1, 60, "ff_timeout");
    repeat (4) @(negedge clock);
    chk("ff_out", put_out.size() > 0 ? put_out[0] : 8'hxx, 8'hFF);
    chk("ff_nput", put_out.size(), 1);

    // reset in the middle of a word
    start_test();
    loop = 1'b1;
    mem[0] = 8'h3C;
    mem[1] = 8'h5A;
    go(2);
    wait_cs(1'b0, 20, "mid_cs_timeout");
    repeat (6) @(negedge clock);
    chk("mid_active", bus.spi_cs_n, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cs_n", bus.spi_cs_n, 1);
    chk("mid_rst_sck", bus.spi_clock, 0);
    chk("mid_rst_mosi", bus.spi_mosi, 0);
    chk("mid_rst_get", bus.get, 0);
    repeat (2) @(negedge clock);
    chk("mid_rst_nput", put_out.size(), 0);
    reset = 1'b1;
    wait_puts(1, 60, "mid_timeout");
    repeat (20) @(negedge clock);
    chk("mid_nput", put_out.size(), 1);
    chk("mid_out", put_out.size() > 0 ? put_out[0] : 8'hxx, 8'h5A);

    // empty toggling: one 1-clock gap, one no-effect toggle
    start_test();
    loop = 1'b1;
    mem[0] = 8'h81;
    mem[1] = 8'h7E;
    mem[2] = 8'hC3;
    go(3);
    wait_cs(1'b0, 20, "tog_cs0_timeout");
    hold = 1'b1;
    wait_cs(1'b1, 40, "tog_cs1_timeout");
    hold = 1'b0;
    wait_cs(1'b0, 5, "tog_cs2_timeout");
    repeat (3) @(negedge clock);
    hold = 1'b1;
    repeat (4) @(negedge clock);
    hold = 1'b0;
    wait_puts(3, 100, "tog_timeout");
    repeat (6) @(negedge clock);
    chk("tog_nput", put_out.size(), 3);
    chk("tog_w0", put_out.size() > 0 ? put_out[0] : 8'hxx, 8'h81);
    chk("tog_w1", put_out.size() > 1 ? put_out[1] : 8'hxx, 8'h7E);
    chk("tog_w2", put_out.size() > 2 ? put_out[2] : 8'hxx, 8'hC3);
    chk("tog_ngaps", gaps.size(), 1);
    chk("tog_gap_len", gaps.size() > 0 ? gaps[0] : -1, 1);
    chk("tog_cs_fall", cs_fall, 2);
    chk("tog_get_empty", get_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
